// File: rtl/mult_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mult_sched_if                                             |
// | Purpose  : Requester handshake and shared multiplier datapath        |
// |            signals of the mult_sched scheduler.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface mult_sched_if #(
  parameter int N = 4
);
  // requester side
  logic           req0;
  logic           req1;
  logic [N-1:0]   a0;
  logic [N-1:0]   b0;
  logic [N-1:0]   a1;
  logic [N-1:0]   b1;
  logic           gnt0;
  logic           gnt1;
  logic           ack0;
  logic           ack1;
  logic [2*N-1:0] result;
  // shared datapath side
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           st;
  logic           done;
  logic [2*N-1:0] p;
  // status
  logic           busy;
  logic           err;

  // scheduler view
  modport slave (
    input  req0, req1, a0, b0, a1, b1, done, p,
    output gnt0, gnt1, ack0, ack1, result, mcand, mplier, st, busy, err
  );

  // environment view (requesters plus datapath)
  modport master (
    output req0, req1, a0, b0, a1, b1, done, p,
    input  gnt0, gnt1, ack0, ack1, result, mcand, mplier, st, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mult_sched                                                |
// | Purpose  : Round-robin scheduler sharing one shift-add multiplier    |
// |            between two requesters (IDLE/START/WAIT/RESP FSM).        |
// | Options  : MULT_SCHED_TIMEOUT_EN adds a WAIT watchdog of TMO cycles  |
// |            that aborts the operation and pulses err.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mult_sched #(
  parameter int N   = 4,
  parameter int TMO = 2*N+4
) (
  input  logic         clk,
  input  logic         rst,
  mult_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;       // preferred requester on a tie
  logic           own_q, own_d;       // requester currently being served
  logic [1:0]     gnt_q, gnt_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] result_q, result_d;
  logic           w_win;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, err_d;
  logic             w_tmo;

  assign w_tmo = (cnt_q == CNT_W'(TMO - 1));
`endif

  // a lone requester wins outright; on a tie the pointer decides
  assign w_win = (bus.req0 & bus.req1) ? ptr_q : bus.req1;

  // state, pointer, grant and captured data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      own_q    <= 1'b0;
      gnt_q    <= 2'b00;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      gnt_q    <= gnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

`ifdef MULT_SCHED_TIMEOUT_EN
  // watchdog: counts cycles spent in WAIT, one-cycle error pulse on expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      err_q <= err_d;
    end
  end
`endif

  // next-state logic: arbitration, start pulse, completion and response
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    gnt_d    = gnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
`ifdef MULT_SCHED_TIMEOUT_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          own_d    = w_win;
          gnt_d    = w_win ? 2'b10 : 2'b01;
          mcand_d  = w_win ? bus.a1 : bus.a0;
          mplier_d = w_win ? bus.b1 : bus.b0;
          state_d  = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.done) begin
          result_d = bus.p;
          state_d  = S_RESP;
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        else if (w_tmo) begin
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          ptr_d   = ~own_q;
          state_d = S_IDLE;
        end
`endif
      end
      S_RESP: begin
        gnt_d   = 2'b00;
        ptr_d   = ~own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.st     = (state_q == S_START);
  assign bus.ack0   = (state_q == S_RESP) & ~own_q;
  assign bus.ack1   = (state_q == S_RESP) &  own_q;
  assign bus.gnt0   = gnt_q[0];
  assign bus.gnt1   = gnt_q[1];
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.mcand  = mcand_q;
  assign bus.mplier = mplier_q;
  assign bus.result = result_q;
`ifdef MULT_SCHED_TIMEOUT_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mult_sched                                             |
// | Purpose  : Directed self-checking bench for mult_sched with a        |
// |            simple datapath stand-in answering each start pulse.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_mult_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_sched_if #(.N(N)) bus ();
  mult_sched #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // datapath stand-in and stray done injection
  logic       dp_en      = 1'b0;
  int         dp_dly     = 6;
  logic       dp_done    = 1'b0;
  logic [7:0] dp_p       = 8'd0;
  logic       stray_done = 1'b0;
  logic [7:0] stray_p    = 8'd0;
  assign bus.done = dp_done | stray_done;
  assign bus.p    = stray_done ? stray_p : dp_p;

  // event counters
  int n_ack0 = 0, n_ack1 = 0, n_st = 0, n_gnt1 = 0, n_excl = 0;

  int         who;
  logic [7:0] res;
  int         s0, a0c, a1c, g1c, cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // wait for an ack, optionally drop that requester, then verify ack is one cycle
  task automatic wait_ack(input string tag, input bit drop, output int w, output logic [7:0] r);
    bit got = 1'b0;
    w = -1;
    r = 8'd0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) got = 1'b1;
    end
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      w = bus.ack1 ? 1 : 0;
      r = bus.result;
      if (drop) begin
        if (w == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
      end
      @(negedge clk);
      check({tag, "_ack_1cyc"}, 32'(bus.ack0 | bus.ack1), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: counts pulses and exclusivity violations
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ack0) n_ack0++;
      if (bus.ack1) n_ack1++;
      if (bus.st)   n_st++;
      if (bus.gnt1) n_gnt1++;
      if ((bus.gnt0 & bus.gnt1) | (bus.ack0 & bus.ack1)) n_excl++;
    end
  end

  // datapath: dp_dly cycles after a start pulse, present the product for one cycle
  initial begin
    forever begin
      @(negedge clk);
      if (bus.st && dp_en) begin
        repeat (dp_dly) @(negedge clk);
        dp_p    = {4'b0, bus.mcand} * {4'b0, bus.mplier};
        dp_done = 1'b1;
        @(negedge clk);
        dp_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_mcand",  32'(bus.mcand),  32'd0);
    check("rst_mplier", 32'(bus.mplier), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_st",     32'(bus.st),     32'd0);
    check("rst_gnt0",   32'(bus.gnt0),   32'd0);
    check("rst_gnt1",   32'(bus.gnt1),   32'd0);
    check("rst_ack0",   32'(bus.ack0),   32'd0);
    check("rst_ack1",   32'(bus.ack1),   32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_err",    32'(bus.err),    32'd0);

    // single requester 0: 5*3
    rst = 1'b0;
    bus.a0 = 4'd5; bus.b0 = 4'd3; bus.req0 = 1'b1;
    dp_en = 1'b1; dp_dly = 6;
    s0 = n_st; g1c = n_gnt1; a1c = n_ack1;
    @(negedge clk);
    check("t1_gnt0",   32'(bus.gnt0),   32'd1);
    check("t1_st",     32'(bus.st),     32'd1);
    check("t1_busy",   32'(bus.busy),   32'd1);
    check("t1_mcand",  32'(bus.mcand),  32'd5);
    check("t1_mplier", 32'(bus.mplier), 32'd3);
    wait_ack("t1", 1'b1, who, res);
    check("t1_who",    32'(who), 32'd0);
    check("t1_result", 32'(res), 32'd15);
    check("t1_st_cnt",   32'(n_st - s0),    32'd1);
    check("t1_gnt1_cnt", 32'(n_gnt1 - g1c), 32'd0);
    check("t1_ack1_cnt", 32'(n_ack1 - a1c), 32'd0);
    check("t1_gnt0_clr", 32'(bus.gnt0), 32'd0);
    check("t1_busy_clr", 32'(bus.busy), 32'd0);

    // both requesters after reset: 0 first (2*3), then 1 (4*4)
    do_reset();
    bus.a0 = 4'd2; bus.b0 = 4'd3; bus.a1 = 4'd4; bus.b1 = 4'd4;
    bus.req0 = 1'b1; bus.req1 = 1'b1; dp_dly = 3;
    wait_ack("t2a", 1'b1, who, res);
    check("t2a_who", 32'(who), 32'd0);
    check("t2a_res", 32'(res), 32'd6);
    wait_ack("t2b", 1'b1, who, res);
    check("t2b_who", 32'(who), 32'd1);
    check("t2b_res", 32'(res), 32'd16);

    // both held for four services: grants alternate 0,1,0,1 (7*9, 15*15)
    bus.a0 = 4'd7; bus.b0 = 4'd9; bus.a1 = 4'd15; bus.b1 = 4'd15;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack($sformatf("t3_%0d", i), 1'b0, who, res);
      check($sformatf("t3_%0d_who", i), 32'(who), 32'(i % 2));
      check($sformatf("t3_%0d_res", i), 32'(res), (i % 2) ? 32'd225 : 32'd63);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // reset during WAIT drops the operation; pending requester 1 then wins
    dp_en = 1'b0;
    bus.a0 = 4'd1; bus.b0 = 4'd1; bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_wait_busy", 32'(bus.busy), 32'd1);
    check("t4_wait_st",   32'(bus.st),   32'd0);
    a0c = n_ack0;
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.a1 = 4'd3; bus.b1 = 4'd5; bus.req1 = 1'b1;
    @(negedge clk);
    check("t4_rst_gnt0",   32'(bus.gnt0),   32'd0);
    check("t4_rst_gnt1",   32'(bus.gnt1),   32'd0);
    check("t4_rst_busy",   32'(bus.busy),   32'd0);
    check("t4_rst_mcand",  32'(bus.mcand),  32'd0);
    check("t4_rst_result", 32'(bus.result), 32'd0);
    check("t4_rst_ack0",   32'(bus.ack0),   32'd0);
    rst = 1'b0; dp_en = 1'b1; dp_dly = 2;
    @(negedge clk);
    check("t4_gnt1", 32'(bus.gnt1), 32'd1);
    check("t4_gnt0", 32'(bus.gnt0), 32'd0);
    wait_ack("t4", 1'b1, who, res);
    check("t4_who",   32'(who), 32'd1);
    check("t4_res",   32'(res), 32'd15);
    check("t4_noack0", 32'(n_ack0 - a0c), 32'd0);

    // done in IDLE and in the start cycle must not capture
    stray_p = 8'hAA; stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("t5_idle_res",  32'(bus.result), 32'd15);
    check("t5_idle_busy", 32'(bus.busy),   32'd0);
    bus.a0 = 4'd2; bus.b0 = 4'd2; bus.req0 = 1'b1; dp_dly = 3;
    @(negedge clk);
    check("t5_st", 32'(bus.st), 32'd1);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("t5_st_res", 32'(bus.result), 32'd15);
    wait_ack("t5", 1'b1, who, res);
    check("t5_res", 32'(res), 32'd4);

    // datapath never answers
    do_reset();
    dp_en = 1'b0;
    a0c = n_ack0;
    bus.req0 = 1'b1;
    @(negedge clk);
    check("t6_st", 32'(bus.st), 32'd1);
`ifdef MULT_SCHED_TIMEOUT_EN
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.err) break;
    end
    check("t6_err_cycle", 32'(cyc),       32'd13);
    check("t6_err",       32'(bus.err),   32'd1);
    check("t6_busy",      32'(bus.busy),  32'd0);
    check("t6_gnt0",      32'(bus.gnt0),  32'd0);
    check("t6_noack",     32'(n_ack0 - a0c), 32'd0);
    bus.req1 = 1'b1;
    @(negedge clk);
    check("t6_err_1cyc",  32'(bus.err),   32'd0);
    check("t6_ptr_gnt1",  32'(bus.gnt1),  32'd1);
`else
    repeat (30) @(negedge clk);
    check("t6_busy_hold", 32'(bus.busy), 32'd1);
    check("t6_err_zero",  32'(bus.err),  32'd0);
    check("t6_noack",     32'(n_ack0 - a0c), 32'd0);
`endif
    do_reset();
    @(negedge clk);

    check("excl", 32'(n_excl), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter N, default 4, operand width in bits of the shared shift-add multiplier.
REQ-002 Parameter TMO, default 2*N+4, watchdog limit in cycles for a multiply (used only under REQ-032).
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 Req0, Req1  in  1 each  requester multiply requests, level, held until acknowledged.
REQ-006 A0, B0, A1, B1  in  N each  multiplicand/multiplier of each requester, stable while Req high.
REQ-007 Mcand, Mplier  out  N each  operands driven to the shared datapath.
REQ-008 St  out  1  start pulse to the multiplier Control unit.
REQ-009 Done  in  1  completion flag from the Control unit.
REQ-010 P  in  2N  product from the datapath accumulator.
REQ-011 Gnt0, Gnt1  out  1 each  one-hot grant, high from grant until acknowledge.
REQ-012 Ack0, Ack1  out  1 each  single-cycle acknowledge; Result valid in the same cycle.
REQ-013 Result  out  2N  captured product.
REQ-014 Busy  out  1  high in any state other than IDLE.
REQ-015 Err  out  1  single-cycle watchdog error flag (constant 0 when REQ-032 is excluded).

Function
REQ-016 FSM states: IDLE, START, WAIT, RESP.
REQ-017 IDLE: if any Req is high, select a winner per REQ-021, latch its operands into Mcand/Mplier, assert its Gnt, and go to START.
REQ-018 START: assert St for exactly one cycle, then go to WAIT.
REQ-019 WAIT: on Done=1, capture P into Result and go to RESP; Done arriving in the same cycle as the St pulse is ignored.
REQ-020 RESP: pulse the granted Ack for one cycle, clear Gnt, advance the priority pointer, and return to IDLE; latency from winning Req to Ack is at least 4 cycles.
REQ-021 Arbitration is round-robin: a 1-bit pointer names the preferred requester; a lone requester wins regardless of the pointer.
REQ-022 When both Req are high, the requester named by the pointer wins; after service the pointer names the other requester.
REQ-023 Mcand, Mplier and Result hold their values outside capture events.
REQ-024 A requester deasserting Req while granted does not abort the operation; the operation completes and Ack is still issued.
REQ-025 The same requester may be re-granted no earlier than the cycle after RESP.
REQ-026 Done is ignored in IDLE, START and RESP.
REQ-027 St, Gnt0/1 and Ack0/1 are never high for both requesters at once.

Reset
REQ-028 Rst high at a clock edge forces IDLE, pointer=0, and all outputs to 0 (Mcand, Mplier, Result, St, Gnt0/1, Ack0/1, Busy, Err).
REQ-029 Rst takes priority over every other input, including mid-operation (START/WAIT/RESP); a pending Ack is dropped.
REQ-030 The first arbitration after reset is evaluated on the first edge with Rst low.

Configuration
REQ-031 The macro MULT_SCHED_TIMEOUT_EN selects the watchdog.
REQ-032 With MULT_SCHED_TIMEOUT_EN defined: a counter counts cycles in WAIT; if it reaches TMO without Done, Err pulses one cycle, Gnt is cleared, no Ack is issued, the pointer advances, and the FSM returns to IDLE.
REQ-033 Without MULT_SCHED_TIMEOUT_EN: no counter exists, Err is tied to 0, and WAIT waits indefinitely.

Verification
REQ-034 Reset then Req0=1, A0=5, B0=3, Done after 6 cycles with P=15 -> Gnt0, one St pulse, Ack0 with Result=15, Gnt1/Ack1 never high.
REQ-035 Req0=Req1=1 after reset, A0=2, B0=3, A1=4, B1=4 -> Req0 served first (Result=6), then Req1 (Result=16), pointer back at 0.
REQ-036 Both Req held high for 4 services -> grants alternate 0,1,0,1; each Ack is exactly one cycle.
REQ-037 Rst asserted during WAIT -> next cycle IDLE, all outputs 0, no Ack; Req1 then pending -> Req1 granted first.
REQ-038 MULT_SCHED_TIMEOUT_EN defined, N=4, Done never asserted -> Err pulses after 12 WAIT cycles, no Ack, Busy drops; without the macro -> Busy stays high and Err stays 0.
REQ-039 Done pulsed during IDLE and during the St cycle -> no capture, Result unchanged.
